// File: rtl/spi_sched_pkg.sv
// Shared types and constants for the SPI transfer scheduler: FSM states,
// SPI core register map and CTRL register bit positions.
package spi_sched_pkg;

  typedef enum logic [3:0] {
    IDLE,
    GRANT,
    WR_DIV,
    WR_TX,
    WR_SS,
    WR_CTRL,
    WAIT_DONE,
    RD_RX,
    RESP
  } sched_state_e;

  localparam logic [4:0] ADR_TX0     = 5'h00;
  localparam logic [4:0] ADR_RX0     = 5'h00;
  localparam logic [4:0] ADR_CTRL    = 5'h10;
  localparam logic [4:0] ADR_DIVIDER = 5'h14;
  localparam logic [4:0] ADR_SS      = 5'h18;

  localparam logic [3:0] SEL_HALF = 4'b0011;
  localparam logic [3:0] SEL_BYTE = 4'b0001;
  localparam logic [3:0] SEL_WORD = 4'b1111;

  localparam int CTRL_CHAR_LEN   = 0;
  localparam int CTRL_CHAR_LEN_W = 5;
  localparam int CTRL_GO         = 8;
  localparam int CTRL_RX_NEG     = 9;
  localparam int CTRL_TX_NEG     = 10;
  localparam int CTRL_LSB        = 11;
  localparam int CTRL_IE         = 12;
  localparam int CTRL_ASS        = 13;

  function automatic logic [31:0] ctrl_word(input logic [4:0] len,
                                            input logic       rx_neg,
                                            input logic       tx_neg,
                                            input logic       lsb,
                                            input logic       ie);
    logic [31:0] w;
    w = '0;
    w[CTRL_CHAR_LEN +: CTRL_CHAR_LEN_W] = len;
    w[CTRL_GO]     = 1'b1;
    w[CTRL_RX_NEG] = rx_neg;
    w[CTRL_TX_NEG] = tx_neg;
    w[CTRL_LSB]    = lsb;
    w[CTRL_IE]     = ie;
    w[CTRL_ASS]    = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr.
module spi_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  // Walk from the farthest offset down so the closest requester wins last.
  always_comb begin
    gnt = '0;
    sum = '0;
    idx = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      sum = {1'b0, ptr} + (PTR_W + 1)'(off);
      if (sum >= (PTR_W + 1)'(NREQ)) sum = sum - (PTR_W + 1)'(NREQ);
      idx = sum[PTR_W-1:0];
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_xfer_scheduler.sv
// Multi-requester SPI transfer scheduler driving a Wishbone SPI master core.
// Define SPI_SCHED_IRQ_EN to wait on the core interrupt instead of polling CTRL.GO.
module spi_xfer_scheduler
  import spi_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int SS_W = 3
) (
  input  logic                 wb_clk_in,
  input  logic                 wb_rst_in,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_data,
  input  logic [5*NREQ-1:0]    req_len,
  input  logic [SS_W*NREQ-1:0] req_ss,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_data,
  input  logic [15:0]          cfg_divider,
  input  logic                 cfg_rx_negedge,
  input  logic                 cfg_tx_negedge,
  input  logic                 cfg_lsb,
  output logic                 m_cyc_o,
  output logic                 m_stb_o,
  output logic                 m_we_o,
  output logic [4:0]           m_adr_o,
  output logic [3:0]           m_sel_o,
  output logic [31:0]          m_dat_o,
  input  logic [31:0]          m_dat_i,
  input  logic                 m_ack_i,
  input  logic                 spi_int_in,
  output logic                 busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  sched_state_e     state_q, state_d;
  logic [NREQ-1:0]  gnt_q, arb_gnt;
  logic [PTR_W-1:0] ptr_q, gnt_idx;
  logic             div_valid_q;
  logic [15:0]      div_shadow_q;
  logic [31:0]      xfer_data;
  logic [4:0]       xfer_len;
  logic [SS_W-1:0]  xfer_ss;
  logic [31:0]      sel_data;
  logic [4:0]       sel_len;
  logic [SS_W-1:0]  sel_ss;
  logic             acc_active, acc_start, acc_ack, acc_we;
  logic [4:0]       acc_adr;
  logic [3:0]       acc_sel;
  logic [31:0]      acc_dat;
  logic             done_seen;

`ifdef SPI_SCHED_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
  assign done_seen = spi_int_in;
`else
  localparam logic IRQ_EN = 1'b0;
  logic unused_spi_int;
  assign unused_spi_int = spi_int_in;
  assign done_seen = acc_ack && !m_dat_i[CTRL_GO];
`endif

  spi_rr_arbiter #(
    .NREQ (NREQ),
    .PTR_W(PTR_W)
  ) u_arb (
    .req(req_valid),
    .ptr(ptr_q),
    .gnt(arb_gnt)
  );

  always_comb begin
    gnt_idx  = '0;
    sel_data = '0;
    sel_len  = '0;
    sel_ss   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) begin
        gnt_idx  = PTR_W'(i);
        sel_data = req_data[32*i +: 32];
        sel_len  = req_len[5*i +: 5];
        sel_ss   = req_ss[SS_W*i +: SS_W];
      end
    end
  end

  // Bus access description for the current state; an ack only counts while cyc is up.
  always_comb begin
    acc_active = 1'b0;
    acc_we     = 1'b0;
    acc_adr    = ADR_TX0;
    acc_sel    = SEL_WORD;
    acc_dat    = '0;
    case (state_q)
      WR_DIV: begin
        acc_active = 1'b1;
        acc_we     = 1'b1;
        acc_adr    = ADR_DIVIDER;
        acc_sel    = SEL_HALF;
        acc_dat    = {16'h0000, cfg_divider};
      end
      WR_TX: begin
        acc_active = 1'b1;
        acc_we     = 1'b1;
        acc_adr    = ADR_TX0;
        acc_sel    = SEL_BYTE;
        acc_dat    = xfer_data;
      end
      WR_SS: begin
        acc_active = 1'b1;
        acc_we     = 1'b1;
        acc_adr    = ADR_SS;
        acc_sel    = SEL_BYTE;
        acc_dat    = 32'd1 << xfer_ss;
      end
      WR_CTRL: begin
        acc_active = 1'b1;
        acc_we     = 1'b1;
        acc_adr    = ADR_CTRL;
        acc_sel    = SEL_HALF;
        acc_dat    = ctrl_word(xfer_len, cfg_rx_negedge, cfg_tx_negedge, cfg_lsb, IRQ_EN);
      end
      WAIT_DONE: begin
        acc_active = !IRQ_EN;
        acc_adr    = ADR_CTRL;
      end
      RD_RX: begin
        acc_active = 1'b1;
        acc_adr    = ADR_RX0;
      end
      default: ;
    endcase
  end

  assign acc_ack   = m_cyc_o && m_ack_i;
  assign acc_start = acc_active && !m_cyc_o;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (|req_valid) state_d = GRANT;
      GRANT:     state_d = (!div_valid_q || (div_shadow_q != cfg_divider)) ? WR_DIV : WR_TX;
      WR_DIV:    if (acc_ack) state_d = WR_TX;
      WR_TX:     if (acc_ack) state_d = WR_SS;
      WR_SS:     if (acc_ack) state_d = WR_CTRL;
      WR_CTRL:   if (acc_ack) state_d = WAIT_DONE;
      WAIT_DONE: if (done_seen) state_d = RD_RX;
      RD_RX:     if (acc_ack) state_d = RESP;
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_in) begin
    if (wb_rst_in) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_ff @(posedge wb_clk_in) begin
    if (wb_rst_in) begin
      gnt_q       <= '0;
      ptr_q       <= '0;
      div_valid_q <= 1'b0;
    end else begin
      if (state_q == IDLE && |req_valid) gnt_q <= arb_gnt;
      if (state_q == GRANT)
        ptr_q <= (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      if (state_q == WR_DIV && acc_ack) div_valid_q <= 1'b1;
    end
  end

  always_ff @(posedge wb_clk_in) begin
    if (state_q == GRANT) begin
      xfer_data <= sel_data;
      xfer_len  <= sel_len;
      xfer_ss   <= sel_ss;
    end
    if (state_q == WR_DIV && acc_ack) div_shadow_q <= m_dat_o[15:0];
  end

  always_ff @(posedge wb_clk_in) begin
    if (wb_rst_in) begin
      m_cyc_o  <= 1'b0;
      m_stb_o  <= 1'b0;
      m_we_o   <= 1'b0;
      m_adr_o  <= '0;
      m_sel_o  <= '0;
      m_dat_o  <= '0;
      rsp_data <= '0;
    end else begin
      if (acc_ack) begin
        m_cyc_o <= 1'b0;
        m_stb_o <= 1'b0;
      end else if (acc_start) begin
        m_cyc_o <= 1'b1;
        m_stb_o <= 1'b1;
        m_we_o  <= acc_we;
        m_adr_o <= acc_adr;
        m_sel_o <= acc_sel;
        m_dat_o <= acc_dat;
      end
      if (acc_ack && state_q == RD_RX) rsp_data <= m_dat_i;
    end
  end

  assign busy      = (state_q != IDLE);
  assign req_ready = (state_q == GRANT) ? gnt_q : '0;
  assign rsp_valid = (state_q == RESP)  ? gnt_q : '0;

endmodule
